cond_unit_pipe: RTL and testbench

COND_UNIT_PIPE -- requirements
Module: cond_unit_pipe

---
 rtl/cond_unit_pipe_if.sv | 32 +++
 rtl/cond_unit_pipe.sv | 73 +++++++
 tb/tb_cond_unit_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cond_unit_pipe_if.sv
// cond_unit_pipe_if: instruction/result handshake bundle for the conditional-execution unit
interface cond_unit_pipe_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] Cond;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic [3:0] ALUFlags;
    logic       ItStart;
    logic [3:0] ItLen;
    logic [3:0] ItCond;
    logic       Flush;
    logic       out_valid;
    logic       out_ready;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;
    logic       ItActive;
    logic [3:0] ItRemain;
    modport master (
        output in_valid, Cond, FlagW, PCS, RegW, MemW, ALUFlags, ItStart, ItLen, ItCond, Flush, out_ready,
        input  in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx, Flags, ItActive, ItRemain
    );
    modport slave (
        input  in_valid, Cond, FlagW, PCS, RegW, MemW, ALUFlags, ItStart, ItLen, ItCond, Flush, out_ready,
        output in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx, Flags, ItActive, ItRemain
    );
endinterface

// File: rtl/cond_unit_pipe.sv
// cond_unit_pipe: ARM-style condition check with NZCV register, predication blocks and a registered
// valid/ready result stage; flags update at acceptance so back-to-back instructions see them.
module cond_unit_pipe #(
    parameter int         IT_DEPTH  = 4,
    parameter logic [3:0] FLAG_INIT = 4'b0000
) (
    input logic clk,
    input logic reset,
    cond_unit_pipe_if.slave bus
);
    localparam logic [3:0] DEPTH = 4'(IT_DEPTH);
    logic [3:0] it_cond;
    logic [3:0] eff;
    logic       base;
    logic       pass;
    logic       cond_ex;
    logic       gate;
    logic       acc;
    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign bus.ItActive = bus.ItRemain != 4'd0;
    // Flags = {N, Z, C, V}; cond[3:1] picks the test, cond[0] inverts it (except AL/1111)
    always_comb begin
        eff = (bus.ItActive && !bus.ItStart) ? it_cond : bus.Cond;
        base = 1'b1;
        case (eff[3:1])
            3'd0: base = bus.Flags[2];
            3'd1: base = bus.Flags[1];
            3'd2: base = bus.Flags[3];
            3'd3: base = bus.Flags[0];
            3'd4: base = bus.Flags[1] & ~bus.Flags[2];
            3'd5: base = bus.Flags[3] == bus.Flags[0];
            3'd6: base = ~bus.Flags[2] & (bus.Flags[3] == bus.Flags[0]);
            default: base = 1'b1;
        endcase
        pass = (eff[3:1] == 3'd7) | (base ^ eff[0]);
        cond_ex = bus.ItStart | pass;
        gate = cond_ex & ~bus.ItStart;
        acc = bus.in_valid & bus.in_ready & ~bus.Flush;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.Flags <= FLAG_INIT;
            bus.ItRemain <= 4'd0;
            it_cond <= 4'd0;
            bus.out_valid <= 1'b0;
            bus.PCSrc <= 1'b0;
            bus.RegWrite <= 1'b0;
            bus.MemWrite <= 1'b0;
            bus.CondEx <= 1'b0;
        end else if (bus.Flush) begin
            bus.out_valid <= 1'b0;
            bus.ItRemain <= 4'd0;
        end else if (acc) begin
            bus.out_valid <= 1'b1;
            bus.CondEx <= cond_ex;
            bus.PCSrc <= bus.PCS & gate;
            bus.RegWrite <= bus.RegW & gate;
            bus.MemWrite <= bus.MemW & gate;
            if (gate & bus.FlagW[1]) bus.Flags[3:2] <= bus.ALUFlags[3:2];
            if (gate & bus.FlagW[0]) bus.Flags[1:0] <= bus.ALUFlags[1:0];
            if (bus.ItStart) begin
                if (bus.ItLen != 4'd0) begin
                    it_cond <= bus.ItCond;
                    bus.ItRemain <= (bus.ItLen > DEPTH) ? DEPTH : bus.ItLen;
                end
            end else if (bus.ItActive) begin
                bus.ItRemain <= bus.ItRemain - 4'd1;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cond_unit_pipe.sv
// tb_cond_unit_pipe: directed scenarios plus randomized traffic against a behavioural model
module tb_cond_unit_pipe;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    cond_unit_pipe_if bus();
    cond_unit_pipe #(.IT_DEPTH(DEPTH), .FLAG_INIT(4'b0000)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    logic [3:0] m_flags, m_rem, m_itc;
    logic       m_ov, m_pc, m_rw, m_mw, m_ce;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            default: return 1'b1;
        endcase
    endfunction
    task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw, input logic pcs,
                         input logic rw, input logic mw, input logic [3:0] alu, input logic its,
                         input logic [3:0] len, input logic [3:0] itc, input logic fl, input logic ordy);
        bus.in_valid = v; bus.Cond = c; bus.FlagW = fw; bus.PCS = pcs; bus.RegW = rw; bus.MemW = mw;
        bus.ALUFlags = alu; bus.ItStart = its; bus.ItLen = len; bus.ItCond = itc; bus.Flush = fl;
        bus.out_ready = ordy;
    endtask
    task automatic model_step();
        logic ok, ce;
        logic [3:0] c;
        if (reset) begin
            m_flags = 4'b0000; m_rem = 0; m_itc = 0; m_ov = 0; m_pc = 0; m_rw = 0; m_mw = 0; m_ce = 0;
        end else if (bus.Flush) begin
            m_ov = 0; m_rem = 0;
        end else if (bus.in_valid && (!m_ov || bus.out_ready)) begin
            c = (m_rem > 0 && !bus.ItStart) ? m_itc : bus.Cond;
            ok = holds(c, m_flags);
            ce = bus.ItStart || ok;
            m_ov = 1; m_ce = ce;
            m_pc = !bus.ItStart && ok && bus.PCS;
            m_rw = !bus.ItStart && ok && bus.RegW;
            m_mw = !bus.ItStart && ok && bus.MemW;
            if (!bus.ItStart && ok && bus.FlagW[1]) m_flags[3:2] = bus.ALUFlags[3:2];
            if (!bus.ItStart && ok && bus.FlagW[0]) m_flags[1:0] = bus.ALUFlags[1:0];
            if (bus.ItStart) begin
                if (bus.ItLen > 0) begin
                    m_itc = bus.ItCond;
                    m_rem = (int'(bus.ItLen) > DEPTH) ? 4'(DEPTH) : bus.ItLen;
                end
            end else if (m_rem > 0) m_rem = m_rem - 1;
        end else if (bus.out_ready) m_ov = 0;
    endtask
    task automatic cycle();
        #1;
        if (!reset) chk("in_ready", 32'(bus.in_ready), 32'(!m_ov || bus.out_ready));
        model_step();
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("flags", 32'(bus.Flags), 32'(m_flags));
        chk("it_remain", 32'(bus.ItRemain), 32'(m_rem));
        chk("it_active", 32'(bus.ItActive), 32'(m_rem != 0));
        chk("ctrl", {28'd0, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.CondEx}, {28'd0, m_pc, m_rw, m_mw, m_ce});
    endtask
    initial begin
        logic [3:0] fl_hold;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        reset = 1;
        cycle(); cycle();
        chk("reset_flags", 32'(bus.Flags), 32'h0);
        chk("reset_ov", 32'(bus.out_valid), 32'h0);
        reset = 0;
        // EQ fails with Z=0: no register write, no flag write
        drive(1, 4'h0, 2'b11, 0, 1, 0, 4'b0100, 0, 0, 0, 0, 1);
        cycle();
        chk("eq_fail_rw", 32'(bus.RegWrite), 32'h0);
        chk("eq_fail_ce", 32'(bus.CondEx), 32'h0);
        chk("eq_fail_flags", 32'(bus.Flags), 32'h0);
        // flag write then back-to-back consumer sees Z=1
        drive(1, 4'hE, 2'b10, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 1);
        cycle();
        drive(1, 4'h0, 2'b00, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 1);
        cycle();
        chk("b2b_rw", 32'(bus.RegWrite), 32'h1);
        chk("b2b_flags", 32'(bus.Flags), 32'b0100);
        // predication block with NE while Z=1
        drive(1, 4'hE, 2'b00, 1, 1, 1, 4'b0000, 1, 4'd2, 4'h1, 0, 1);
        cycle();
        chk("it_start_rem", 32'(bus.ItRemain), 32'd2);
        chk("it_start_ctrl", {29'd0, bus.PCSrc, bus.RegWrite, bus.CondEx}, 32'b001);
        drive(1, 4'hE, 2'b00, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 1);
        cycle(); chk("it1_rw", 32'(bus.RegWrite), 32'h0); chk("it1_rem", 32'(bus.ItRemain), 32'd1);
        cycle(); chk("it2_rw", 32'(bus.RegWrite), 32'h0); chk("it2_rem", 32'(bus.ItRemain), 32'd0);
        cycle(); chk("it3_rw", 32'(bus.RegWrite), 32'h1); chk("it3_rem", 32'(bus.ItRemain), 32'd0);
        // stall for three cycles, flags and outputs must hold
        fl_hold = bus.Flags;
        drive(1, 4'hE, 2'b11, 0, 0, 0, 4'b1011, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_ready", 32'(bus.in_ready), 32'h0);
            chk("stall_flags", 32'(bus.Flags), 32'(fl_hold));
        end
        bus.out_ready = 1;
        cycle(); cycle();
        chk("release_flags", 32'(bus.Flags), 32'b1011);
        // flush during active block with a stalled result
        drive(1, 4'hE, 2'b00, 0, 0, 0, 4'b0000, 1, 4'd3, 4'h0, 0, 1);
        cycle();
        bus.ItStart = 0; bus.out_ready = 0;
        cycle();
        chk("pre_flush_rem", 32'(bus.ItRemain), 32'd3);
        fl_hold = bus.Flags;
        bus.Flush = 1;
        cycle();
        chk("flush_ov", 32'(bus.out_valid), 32'h0);
        chk("flush_rem", 32'(bus.ItRemain), 32'h0);
        chk("flush_flags", 32'(bus.Flags), 32'(fl_hold));
        // saturation, then reset mid-block
        drive(1, 4'hE, 2'b00, 0, 0, 0, 4'b0000, 1, 4'd9, 4'h0, 0, 1);
        cycle();
        chk("sat_rem", 32'(bus.ItRemain), 32'd4);
        bus.ItStart = 0; bus.out_ready = 0; bus.FlagW = 2'b11; bus.ALUFlags = 4'hF;
        cycle();
        reset = 1;
        cycle();
        chk("mid_reset", {bus.out_valid, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.CondEx, bus.ItActive, bus.ItRemain, bus.Flags}, 14'd0);
        reset = 0;
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(99) == 0);
            drive($urandom_range(3) != 0, 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  4'($urandom), $urandom_range(6) == 0, 4'($urandom), 4'($urandom),
                  $urandom_range(19) == 0, $urandom_range(3) != 0);
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
